// File: rtl/ks_poly_string.sv
// Polyphonic Karplus-Strong string engine: NUM_VOICES voices share one datapath, one voice per cycle.
// Define KS_DRUM_EN to enable the per-pluck drum timbre (random sign flip of the averaged sample).
module ks_poly_string #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned MAX_LENGTH = 64,
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                                            clk_i,
  input  logic                                            rst_n,
  input  logic                                            sample_tick_i,
  input  logic                                            round_en_i,
  input  logic                                            pluck_valid_i,
  output logic                                            pluck_ready_o,
  input  logic [$clog2(NUM_VOICES)-1:0]                   pluck_voice_i,
  input  logic [DATA_WIDTH-1:0]                           pluck_period_i,
  input  logic                                            pluck_drum_i,
  output logic signed [DATA_WIDTH+$clog2(NUM_VOICES)-1:0] mix_o,
  output logic                                            mix_valid_o,
  output logic [NUM_VOICES-1:0]                           voice_active_o,
  output logic                                            tick_drop_o
);

  localparam int unsigned VoiceW = $clog2(NUM_VOICES);
  localparam int unsigned PtrW   = $clog2(MAX_LENGTH);
  localparam int unsigned LenW   = $clog2(MAX_LENGTH + 1);
  localparam int unsigned MixW   = DATA_WIDTH + VoiceW;
  localparam int unsigned Depth  = NUM_VOICES << PtrW;
  localparam logic [DATA_WIDTH-1:0] PeakPos = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] PeakNeg = {1'b1, {(DATA_WIDTH-2){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StVoice, StMix} state_e;

  state_e                   state_q, state_d;
  logic [VoiceW-1:0]        voice_q, voice_d;
  logic signed [MixW-1:0]   acc_q, acc_d, mix_q, mix_d;
  logic [15:0]              lfsr_q, lfsr_d;
  logic                     mix_valid_q, mix_valid_d, tick_drop_q, tick_drop_d;
  logic [DATA_WIDTH-1:0]    mem_q [Depth];
  logic [LenW-1:0]          period_q [NUM_VOICES], period_d [NUM_VOICES];
  logic [LenW-1:0]          burst_cnt_q [NUM_VOICES], burst_cnt_d [NUM_VOICES];
  logic [LenW-1:0]          zero_cnt_q [NUM_VOICES], zero_cnt_d [NUM_VOICES];
  logic [PtrW-1:0]          ptr_q [NUM_VOICES], ptr_d [NUM_VOICES];
  logic [DATA_WIDTH-1:0]    prev_q [NUM_VOICES], prev_d [NUM_VOICES];
  logic [NUM_VOICES-1:0]    active_q, active_d;
`ifdef KS_DRUM_EN
  logic [NUM_VOICES-1:0]    drum_q, drum_d;
`else
  logic                     unused_drum;
  assign unused_drum = pluck_drum_i;
`endif

  logic                       mem_we;
  logic [VoiceW+PtrW-1:0]     rd_addr, mem_waddr;
  logic [DATA_WIDTH-1:0]      mem_wdata;
  logic signed [DATA_WIDTH-1:0] cur_x, cur_p, avg, step_y;
  logic signed [DATA_WIDTH:0] avg_sum;
  logic                       in_burst;
  logic [LenW-1:0]            zero_next, plen;
  logic [31:0]                per_ext;
  logic                       unused_lsb;

  assign unused_lsb = avg_sum[0];

  // Datapath for the voice selected by voice_q.
  always_comb begin
    rd_addr  = {voice_q, ptr_q[voice_q]};
    cur_x    = mem_q[rd_addr];
    cur_p    = prev_q[voice_q];
    in_burst = burst_cnt_q[voice_q] < period_q[voice_q];
    avg_sum  = {cur_x[DATA_WIDTH-1], cur_x} + {cur_p[DATA_WIDTH-1], cur_p}
             + {{DATA_WIDTH{1'b0}}, round_en_i};
    avg      = avg_sum[DATA_WIDTH:1];
`ifdef KS_DRUM_EN
    if (drum_q[voice_q] && !lfsr_q[1]) avg = -avg;
`endif
    step_y   = in_burst ? (lfsr_q[0] ? PeakPos : PeakNeg) : avg;
  end

  always_comb begin
    state_d     = state_q;
    voice_d     = voice_q;
    acc_d       = acc_q;
    lfsr_d      = lfsr_q;
    mix_d       = mix_q;
    mix_valid_d = 1'b0;
    tick_drop_d = 1'b0;
    period_d    = period_q;
    burst_cnt_d = burst_cnt_q;
    zero_cnt_d  = zero_cnt_q;
    ptr_d       = ptr_q;
    prev_d      = prev_q;
    active_d    = active_q;
`ifdef KS_DRUM_EN
    drum_d      = drum_q;
`endif
    mem_we      = 1'b0;
    mem_waddr   = rd_addr;
    mem_wdata   = step_y;
    zero_next   = '0;
    per_ext     = 32'(pluck_period_i);
    if (per_ext < 32'd2)            plen = LenW'(2);
    else if (per_ext > MAX_LENGTH)  plen = LenW'(MAX_LENGTH);
    else                            plen = LenW'(per_ext);

    unique case (state_q)
      StIdle: begin
        if (pluck_valid_i) begin
          period_d[pluck_voice_i]    = plen;
          ptr_d[pluck_voice_i]       = '0;
          burst_cnt_d[pluck_voice_i] = '0;
          zero_cnt_d[pluck_voice_i]  = '0;
          active_d[pluck_voice_i]    = 1'b1;
`ifdef KS_DRUM_EN
          drum_d[pluck_voice_i]      = pluck_drum_i;
`endif
        end
        if (sample_tick_i) begin
          state_d = StVoice;
          voice_d = '0;
        end
      end
      StVoice: begin
        tick_drop_d     = sample_tick_i;
        mem_we          = 1'b1;
        prev_d[voice_q] = cur_x;
        ptr_d[voice_q]  = (LenW'(ptr_q[voice_q]) == period_q[voice_q] - LenW'(1)) ?
                          '0 : ptr_q[voice_q] + PtrW'(1);
        // Zero-run counter saturates at the period so it cannot wrap back to "sounding".
        if (step_y == '0) begin
          zero_next = (zero_cnt_q[voice_q] < period_q[voice_q]) ?
                      zero_cnt_q[voice_q] + LenW'(1) : zero_cnt_q[voice_q];
        end
        zero_cnt_d[voice_q] = zero_next;
        if (in_burst) begin
          burst_cnt_d[voice_q] = burst_cnt_q[voice_q] + LenW'(1);
        end else if (zero_next == period_q[voice_q]) begin
          active_d[voice_q] = 1'b0;
        end
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        acc_d  = ((voice_q == '0) ? '0 : acc_q) + {{VoiceW{step_y[DATA_WIDTH-1]}}, step_y};
        if (voice_q == VoiceW'(NUM_VOICES - 1)) state_d = StMix;
        else                                     voice_d = voice_q + VoiceW'(1);
      end
      StMix: begin
        tick_drop_d = sample_tick_i;
        mix_d       = acc_q;
        mix_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      voice_q     <= '0;
      acc_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      mix_q       <= '0;
      mix_valid_q <= 1'b0;
      tick_drop_q <= 1'b0;
      active_q    <= '0;
`ifdef KS_DRUM_EN
      drum_q      <= '0;
`endif
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      for (int v = 0; v < int'(NUM_VOICES); v++) begin
        period_q[v]    <= '0;
        burst_cnt_q[v] <= '0;
        zero_cnt_q[v]  <= '0;
        ptr_q[v]       <= '0;
        prev_q[v]      <= '0;
      end
    end else begin
      state_q     <= state_d;
      voice_q     <= voice_d;
      acc_q       <= acc_d;
      lfsr_q      <= lfsr_d;
      mix_q       <= mix_d;
      mix_valid_q <= mix_valid_d;
      tick_drop_q <= tick_drop_d;
      active_q    <= active_d;
`ifdef KS_DRUM_EN
      drum_q      <= drum_d;
`endif
      period_q    <= period_d;
      burst_cnt_q <= burst_cnt_d;
      zero_cnt_q  <= zero_cnt_d;
      ptr_q       <= ptr_d;
      prev_q      <= prev_d;
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign pluck_ready_o  = (state_q == StIdle);
  assign mix_o          = mix_q;
  assign mix_valid_o    = mix_valid_q;
  assign voice_active_o = active_q;
  assign tick_drop_o    = tick_drop_q;

endmodule

// File: tb/tb_ks_poly_string.sv
// Randomized bench for ks_poly_string against a frame-level behavioural model of the string engine.
module tb_ks_poly_string;
  localparam int NV = 4;
  localparam int ML = 64;
`ifdef KS_DRUM_EN
  localparam bit DrumEn = 1'b1;
`else
  localparam bit DrumEn = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_n = 1'b0;
  logic              sample_tick_i = 1'b0, round_en_i = 1'b0, pluck_valid_i = 1'b0;
  logic              pluck_drum_i = 1'b0;
  logic [1:0]        pluck_voice_i = '0;
  logic [7:0]        pluck_period_i = '0;
  logic              pluck_ready_o, mix_valid_o, tick_drop_o;
  logic signed [9:0] mix_o;
  logic [3:0]        voice_active_o;

  always #5 clk_i = ~clk_i;

  ks_poly_string dut (
    .clk_i          (clk_i),
    .rst_n          (rst_n),
    .sample_tick_i  (sample_tick_i),
    .round_en_i     (round_en_i),
    .pluck_valid_i  (pluck_valid_i),
    .pluck_ready_o  (pluck_ready_o),
    .pluck_voice_i  (pluck_voice_i),
    .pluck_period_i (pluck_period_i),
    .pluck_drum_i   (pluck_drum_i),
    .mix_o          (mix_o),
    .mix_valid_o    (mix_valid_o),
    .voice_active_o (voice_active_o),
    .tick_drop_o    (tick_drop_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: one delay line per voice plus the shared noise source.
  int m_mem [NV][ML];
  int m_period [NV], m_ptr [NV], m_burst [NV], m_zero [NV], m_prev [NV];
  bit m_active [NV], m_drum [NV];
  int m_lfsr;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_pluck(input int v, input int per, input bit drum);
    m_period[v] = (per < 2) ? 2 : ((per > ML) ? ML : per);
    m_ptr[v]    = 0;
    m_burst[v]  = 0;
    m_zero[v]   = 0;
    m_active[v] = 1'b1;
    m_drum[v]   = drum;
  endfunction

  function automatic int model_frame(input int rnd);
    int sum, x, y;
    bit burst;
    sum = 0;
    for (int v = 0; v < NV; v++) begin
      x     = m_mem[v][m_ptr[v]];
      burst = m_burst[v] < m_period[v];
      if (burst) begin
        y = (m_lfsr % 2 == 1) ? 127 : -127;
        m_burst[v]++;
      end else begin
        y = (x + m_prev[v] + rnd) >>> 1;
        if (DrumEn && m_drum[v] && ((m_lfsr >> 1) % 2 == 0)) y = -y;
      end
      m_zero[v] = (y == 0) ? m_zero[v] + 1 : 0;
      if (!burst && m_zero[v] >= m_period[v]) m_active[v] = 1'b0;
      m_mem[v][m_ptr[v]] = y;
      m_prev[v] = x;
      m_ptr[v]  = (m_ptr[v] == m_period[v] - 1) ? 0 : (m_ptr[v] + 1) % ML;
      m_lfsr    = (m_lfsr % 2 == 1) ? ((m_lfsr >> 1) ^ 'hB400) : (m_lfsr >> 1);
      sum += y;
    end
    return sum;
  endfunction

  function automatic int exp_active();
    int a;
    a = 0;
    for (int v = 0; v < NV; v++) if (m_active[v]) a |= (1 << v);
    return a;
  endfunction

  task automatic pluck_only(input int pv, input int pp, input bit pd);
    @(posedge clk_i); #1;
    check_eq("ready_before_pluck", int'(pluck_ready_o), 1);
    pluck_valid_i = 1'b1; pluck_voice_i = pv[1:0]; pluck_period_i = pp[7:0]; pluck_drum_i = pd;
    @(posedge clk_i); #1;
    pluck_valid_i = 1'b0;
    model_pluck(pv, pp, pd);
    check_eq("active_after_pluck", int'(voice_active_o), exp_active());
  endtask

  // pk_now: pluck together with the tick; pk_late: pluck held valid while the frame runs.
  task automatic run_frame(input int rnd, input bit pk_now, input bit pk_late, input int pv,
                           input int pp, input bit pd, input int drop_at);
    int n, drops, exp_mix;
    @(posedge clk_i); #1;
    check_eq("ready_idle", int'(pluck_ready_o), 1);
    check_eq("valid_pulse", int'(mix_valid_o), 0);
    sample_tick_i = 1'b1;
    round_en_i    = rnd[0];
    if (pk_now) begin
      pluck_valid_i = 1'b1; pluck_voice_i = pv[1:0]; pluck_period_i = pp[7:0]; pluck_drum_i = pd;
    end
    @(posedge clk_i); #1;
    sample_tick_i = 1'b0;
    pluck_valid_i = 1'b0;
    if (pk_now) model_pluck(pv, pp, pd);
    exp_mix = model_frame(rnd);
    if (pk_late) begin
      pluck_valid_i = 1'b1; pluck_voice_i = pv[1:0]; pluck_period_i = pp[7:0]; pluck_drum_i = pd;
    end
    n = 0;
    drops = 0;
    while (!mix_valid_o && n < 20) begin
      sample_tick_i = (drop_at > 0 && n == drop_at - 1);
      @(posedge clk_i); #1;
      n++;
      if (tick_drop_o) drops++;
      if (pk_late && n == 2) check_eq("ready_busy", int'(pluck_ready_o), 0);
    end
    sample_tick_i = 1'b0;
    check_eq("latency", n, 5);
    check_eq("mix", int'(mix_o), exp_mix);
    check_eq("active", int'(voice_active_o), exp_active());
    check_eq("tick_drop_count", drops, (drop_at > 0) ? 1 : 0);
    if (pk_late) begin
      check_eq("ready_back", int'(pluck_ready_o), 1);
      @(posedge clk_i); #1;
      pluck_valid_i = 1'b0;
      model_pluck(pv, pp, pd);
    end
  endtask

  initial begin
    int r, pv, pp, rnd;
    bit pd;
    for (int v = 0; v < NV; v++) begin
      for (int k = 0; k < ML; k++) m_mem[v][k] = 0;
      m_period[v] = 0; m_ptr[v] = 0; m_burst[v] = 0; m_zero[v] = 0; m_prev[v] = 0;
      m_active[v] = 1'b0; m_drum[v] = 1'b0;
    end
    m_lfsr = 'hACE1;

    #2;
    check_eq("rst_mix", int'(mix_o), 0);
    check_eq("rst_mix_valid", int'(mix_valid_o), 0);
    check_eq("rst_active", int'(voice_active_o), 0);
    check_eq("rst_tick_drop", int'(tick_drop_o), 0);
    check_eq("rst_ready", int'(pluck_ready_o), 1);
    repeat (2) @(posedge clk_i);
    #1 rst_n = 1'b1;

    repeat (3) run_frame(0, 1'b0, 1'b0, 0, 0, 1'b0, 0);

    // Single string, period 10: burst then decay with truncating average.
    pluck_only(2, 10, 1'b0);
    repeat (10) run_frame(0, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    repeat (40) run_frame(0, 1'b0, 1'b0, 0, 0, 1'b0, 0);

    // Period clamping, plucks coinciding with ticks.
    run_frame(1, 1'b1, 1'b0, 0, 0, 1'b1, 0);
    run_frame(0, 1'b1, 1'b0, 1, 1, 1'b0, 0);
    run_frame(1, 1'b1, 1'b0, 3, 200, 1'b1, 0);
    run_frame(0, 1'b1, 1'b0, 2, 8, 1'b1, 0);
    for (int i = 0; i < 70; i++) begin
      rnd = $urandom_range(0, 1);
      run_frame(rnd, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    end

    run_frame(0, 1'b0, 1'b0, 0, 0, 1'b0, 2);
    run_frame(1, 1'b0, 1'b1, 1, 5, 1'b1, 0);
    run_frame(0, 1'b0, 1'b0, 0, 0, 1'b0, 0);

    for (int i = 0; i < 150; i++) begin
      r   = $urandom_range(0, 9);
      pv  = $urandom_range(0, 3);
      pp  = $urandom_range(0, 255);
      pd  = 1'($urandom_range(0, 1));
      rnd = $urandom_range(0, 1);
      if (r == 0) begin
        pluck_only(pv, pp, pd);
        run_frame(rnd, 1'b0, 1'b0, 0, 0, 1'b0, 0);
      end else if (r == 1) begin
        run_frame(rnd, 1'b1, 1'b0, pv, pp, pd, 0);
      end else if (r == 2) begin
        run_frame(rnd, 1'b0, 1'b1, pv, pp, pd, 0);
      end else begin
        run_frame(rnd, 1'b0, 1'b0, 0, 0, 1'b0, (r == 3) ? 2 : ((r == 4) ? 3 : 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
